seq_divider: RTL and testbench

- Sequential restoring divider; the inverse companion to the shift-add sequential multiplier.
- Computes an unsigned quotient and remainder, one bit per two clock cycles.
- Contains a control FSM and a shift/subtract datapath. Talks to its host through a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic unit and shares its operand width.

---
 rtl/arith_pkg.sv | 29 ++
 rtl/seq_divider_control.sv | 75 +++++++
 rtl/seq_divider.sv | 111 +++++++++++
 tb/tb_seq_divider.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_pkg
// Description : Constants and types shared by the sequential arithmetic unit
//               (shift-add multiplier and restoring divider).
// Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

  // Operand width shared by the multiplier and the divider
  localparam int DEFAULT_WIDTH = 4;

  // Divider control FSM encoding
  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t INIT  = 3'd1;
  localparam state_t SHIFT = 3'd2;
  localparam state_t TEST  = 3'd3;
  localparam state_t DONE  = 3'd4;

  // Bits needed for a counter that must hold the value w itself
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_control.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_control
// Description : Control FSM of the restoring divider. Sequences the operand
//               load, the shift/trial-subtract loop and the result latch, and
//               drives the start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider_control
  import arith_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic divisor_zero,
  input  logic cnt_zero,
  input  logic t_neg,
  output logic load,
  output logic shift,
  output logic sub_commit,
  output logic latch_result,
  output logic busy,
  output logic done
);

  state_t state;
  state_t state_next;

  // State register; reset abandons any division in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start is only looked at while idle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = INIT;
      INIT:    state_next = divisor_zero ? DONE : SHIFT;
      SHIFT:   state_next = TEST;
      TEST:    state_next = cnt_zero ? DONE : SHIFT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: datapath strobes and handshake flags per state
  always_comb begin
    load         = 1'b0;
    shift        = 1'b0;
    sub_commit   = 1'b0;
    latch_result = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      IDLE: busy = 1'b0;
      INIT: load = 1'b1;
      SHIFT: shift = 1'b1;
      TEST: begin
        // Keep the difference only when it did not go negative
        sub_commit   = ~t_neg;
        // Last bit resolved: capture results on the way into DONE
        latch_result = cnt_zero;
      end
      DONE: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Unsigned sequential restoring divider. Resolves one quotient
//               bit every two clocks (shift, then trial subtract). Divide by
//               zero short-circuits to quotient=all ones, remainder=dividend.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  // Working registers: partial remainder, dividend/quotient shifter, divisor
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] div_r;
  logic [CNT_W-1:0] cnt;

  // Control strobes and status
  logic load;
  logic shift;
  logic sub_commit;
  logic latch_result;
  logic divisor_zero;
  logic cnt_zero;
  logic t_neg;

  // Trial difference, one bit wider than the operands so its MSB is the sign
  logic [WIDTH:0] trial;

  assign trial        = rem_r - {1'b0, div_r};
  assign t_neg        = trial[WIDTH];
  assign cnt_zero     = (cnt == '0);
  // Checked against the live input because it is only used during INIT
  assign divisor_zero = (divisor == '0);

  seq_divider_control u_control (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .divisor_zero (divisor_zero),
    .cnt_zero     (cnt_zero),
    .t_neg        (t_neg),
    .load         (load),
    .shift        (shift),
    .sub_commit   (sub_commit),
    .latch_result (latch_result),
    .busy         (busy),
    .done         (done)
  );

  // Datapath: load operands, shift {R,Q} left, commit non-negative trials
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r <= '0;
      quo_r <= '0;
      div_r <= '0;
      cnt   <= '0;
    end else if (load) begin
      rem_r <= '0;
      quo_r <= dividend;
      div_r <= divisor;
      cnt   <= CNT_W'(WIDTH);
    end else if (shift) begin
      rem_r <= {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
      quo_r <= {quo_r[WIDTH-2:0], 1'b0};
      cnt   <= cnt - CNT_W'(1);
    end else if (sub_commit) begin
      rem_r    <= trial;
      quo_r[0] <= 1'b1;
    end
  end

  // Result registers: updated only when a division completes, held otherwise.
  // The final TEST outcome is folded in directly so results are valid in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (load) begin
      if (divisor_zero) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        div_by_zero <= 1'b0;
      end
    end else if (latch_result) begin
      quotient  <= {quo_r[WIDTH-1:1], ~t_neg};
      remainder <= t_neg ? rem_r[WIDTH-1:0] : trial[WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Scoreboard bench for seq_divider. The driver pushes expected
//               results (plain integer division) with their due cycle; a
//               monitor pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    int q;
    int r;
    int dbz;
    int due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Edge counter: at the negedge after edge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_quotient"}, 32'(quotient), 0);
    check({tag, "_remainder"}, 32'(remainder), 0);
    check({tag, "_dbz"}, 32'(div_by_zero), 0);
  endtask

  // Reference model: ordinary integer division with the divide-by-zero rule
  function automatic exp_t model(input int a, input int b, input int sample_cyc);
    exp_t e;
    if (b == 0) begin
      e.q = MASK; e.r = a; e.dbz = 1; e.due = sample_cyc + 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 0; e.due = sample_cyc + 2 * W + 1;
    end
    return e;
  endfunction

  // Issue one division; returns at the negedge just after the INIT cycle
  task automatic do_op(input int a, input int b, input bit hold_start, input bit scramble);
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) check("idle_timeout", 32'(busy), 0);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!busy && guard < 10);
    if (!busy) begin
      check("start_timeout", 32'(busy), 1);
    end else begin
      sb.push_back(model(a, b, cyc));
    end
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    if (scramble) begin
      repeat (3) begin
        dividend = W'($urandom);
        divisor  = W'($urandom);
        start    = 1'($urandom);
        @(negedge clk);
      end
      start = hold_start;
    end
  endtask

  // Monitor: scoreboard compare on done, result-hold check while busy
  initial begin : monitor
    exp_t e;
    logic [W-1:0] last_q;
    logic [W-1:0] last_r;
    logic prev_done;
    last_q = '0;
    last_r = '0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_q = '0;
        last_r = '0;
        prev_done = 1'b0;
      end else begin
        if (done) begin
          check("done_width", 32'(prev_done), 0);
          if (sb.size() == 0) begin
            check("unexpected_done", 32'(sb.size()), 1);
          end else begin
            e = sb.pop_front();
            check("quotient", 32'(quotient), 32'(e.q));
            check("remainder", 32'(remainder), 32'(e.r));
            check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            check("latency", 32'(cyc), 32'(e.due));
          end
          last_q = quotient;
          last_r = remainder;
        end else if (busy) begin
          check("hold_quotient", 32'(quotient), 32'(last_q));
          check("hold_remainder", 32'(remainder), 32'(last_r));
        end
        prev_done = done;
      end
    end
  end

  initial begin : driver
    int a;
    int b;
    bit hs;
    bit sc;
    int guard;

    #2;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op(13, 3, 0, 0);
    do_op(15, 1, 0, 0);
    do_op(2, 5, 0, 0);
    do_op(7, 0, 0, 0);
    do_op(9, 3, 0, 0);
    do_op(14, 4, 0, 1);
    do_op(0, 6, 0, 0);

    // Asynchronous reset while in TEST of 11/2: no done may follow
    do_op(11, 2, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_state("midreset");
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    do_op(11, 2, 0, 0);

    // Back-to-back with start held high across DONE
    do_op(6, 4, 1, 0);
    do_op(9, 2, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      a  = int'($urandom_range(0, MASK));
      b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, MASK));
      hs = (i < 39) && ($urandom_range(0, 1) == 1);
      sc = (b != 0) && ($urandom_range(0, 3) == 0);
      do_op(a, b, hs, sc);
    end

    // Drain outstanding results, then watch for stray done pulses
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 32'(sb.size()), 0);
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
